// File: rtl/galaga_pkg.sv
// galaga_pkg -- shared types for the Galaga-style game blocks.
//   coord_t  : 10-bit pixel coordinate
//   slot_t   : one rocket slot record (active flag + position)
//   SCREEN_W / SCREEN_H : visible screen size in pixels
package galaga_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic   active;
        coord_t x;
        coord_t y;
    } slot_t;

endpackage

// File: rtl/rocket_pool_if.sv
// rocket_pool_if -- game-side bus of the rocket pool.
//   master : game logic / bench (drives frame_tick, enable, shoot, ship_x/y, hit)
//   slave  : rocket_pool (drives active, rock_x/y, fired, dropped, free_count)
interface rocket_pool_if #(
    parameter int N_SLOTS = 15
);
    logic                                  frame_tick;
    logic                                  enable;
    logic                                  shoot;
    galaga_pkg::coord_t                    ship_x;
    galaga_pkg::coord_t                    ship_y;
    logic [N_SLOTS-1:0]                    hit;
    logic [N_SLOTS-1:0]                    active;
    galaga_pkg::coord_t [N_SLOTS-1:0]      rock_x;
    galaga_pkg::coord_t [N_SLOTS-1:0]      rock_y;
    logic                                  fired;
    logic                                  dropped;
    logic [5:0]                            free_count;

    modport master (
        output frame_tick, enable, shoot, ship_x, ship_y, hit,
        input  active, rock_x, rock_y, fired, dropped, free_count
    );

    modport slave (
        input  frame_tick, enable, shoot, ship_x, ship_y, hit,
        output active, rock_x, rock_y, fired, dropped, free_count
    );
endinterface

// File: rtl/lowest_free_enc.sv
// lowest_free_enc -- priority encoder returning the lowest set bit.
//   i_free  : one bit per slot, 1 = slot available
//   o_idx   : index of the lowest available slot (0 when none)
//   o_found : at least one slot available
module lowest_free_enc #(
    parameter int N     = 15,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     i_free,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // Scan from the top down so the lowest set bit is the last to write.
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_free[i]) o_idx = IDX_W'(i);
        end
    end

    assign o_found = |i_free;

endmodule

// File: rtl/rocket_pool.sv
// rocket_pool -- fixed pool of player rockets, advanced once per video frame.
//   i_Clk     : system clock, rising edge
//   i_Reset_n : synchronous active-low reset
//   io_bus    : rocket_pool_if.slave (frame_tick/enable/shoot/ship/hit in,
//               active/rock_x/rock_y/fired/dropped/free_count out, all registered)
module rocket_pool
    import galaga_pkg::*;
#(
    parameter int N_SLOTS   = 15,
    parameter int SPEED     = 4,
    parameter int COOLDOWN  = 8,
    parameter int AUTO_FIRE = 0,
    parameter int SPAWN_OFS = 8
) (
    input  logic          i_Clk,
    input  logic          i_Reset_n,
    rocket_pool_if.slave  io_bus
);

    localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    slot_t              r_slots [N_SLOTS];
    slot_t              w_nxt   [N_SLOTS];
    logic [7:0]         r_cooldown;
    logic               r_shoot_prev;
    logic               r_fired;
    logic               r_dropped;
    logic [5:0]         r_free_count;

    logic [N_SLOTS-1:0] w_free;
    logic [IDX_W-1:0]   w_free_idx;
    logic               w_found;
    logic [7:0]         w_cd_dec;
    logic               w_req;
    logic               w_fire;
    logic               w_drop;
    coord_t             w_spawn_y;
    logic [5:0]         w_free_count;

    // Allocation looks only at registered state, so a slot freed this cycle
    // is not reusable until a later frame.
    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) w_free[i] = ~r_slots[i].active;
    end

    lowest_free_enc #(.N(N_SLOTS), .IDX_W(IDX_W)) u_enc (
        .i_free  (w_free),
        .o_idx   (w_free_idx),
        .o_found (w_found)
    );

    // Auto-fire gates on the cooldown as it will stand after this frame's
    // decrement, so shots land exactly COOLDOWN frames apart.
    assign w_cd_dec  = (r_cooldown != 8'd0) ? r_cooldown - 8'd1 : 8'd0;
    assign w_req     = io_bus.frame_tick & io_bus.shoot &
                       ((AUTO_FIRE != 0) ? (w_cd_dec == 8'd0) : ~r_shoot_prev);
    assign w_fire    = w_req & io_bus.enable & w_found;
    assign w_drop    = w_req & io_bus.enable & ~w_found;
    assign w_spawn_y = (io_bus.ship_y < coord_t'(SPAWN_OFS)) ? '0
                     : io_bus.ship_y - coord_t'(SPAWN_OFS);

    always_comb begin
        w_free_count = 6'(N_SLOTS);
        for (int i = 0; i < N_SLOTS; i++) begin
            w_nxt[i] = r_slots[i];
            if (io_bus.hit[i] && r_slots[i].active) begin
                // Hit wins over move/retire in any cycle.
                w_nxt[i].active = 1'b0;
            end else if (io_bus.frame_tick) begin
                if (r_slots[i].active) begin
                    // Retire instead of letting y underflow past the top.
                    if (r_slots[i].y >= coord_t'(SPEED))
                        w_nxt[i].y = r_slots[i].y - coord_t'(SPEED);
                    else
                        w_nxt[i].active = 1'b0;
                end else if (w_fire && (w_free_idx == IDX_W'(i))) begin
                    w_nxt[i].active = 1'b1;
                    w_nxt[i].x      = io_bus.ship_x;
                    w_nxt[i].y      = w_spawn_y;
                end
            end
            w_free_count = w_free_count - 6'(w_nxt[i].active);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < N_SLOTS; i++) r_slots[i] <= '0;
            r_cooldown   <= 8'd0;
            r_shoot_prev <= 1'b0;
            r_fired      <= 1'b0;
            r_dropped    <= 1'b0;
            r_free_count <= 6'(N_SLOTS);
        end else begin
            for (int i = 0; i < N_SLOTS; i++) r_slots[i] <= w_nxt[i];
            r_fired      <= w_fire;
            r_dropped    <= w_drop;
            r_free_count <= w_free_count;
            if (io_bus.frame_tick) begin
                r_shoot_prev <= io_bus.shoot;
                r_cooldown   <= w_fire ? 8'(COOLDOWN) : w_cd_dec;
            end
        end
    end

    always_comb begin
        io_bus.active = '0;
        io_bus.rock_x = '0;
        io_bus.rock_y = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            io_bus.active[i] = r_slots[i].active;
            io_bus.rock_x[i] = r_slots[i].x;
            io_bus.rock_y[i] = r_slots[i].y;
        end
    end

    assign io_bus.fired      = r_fired;
    assign io_bus.dropped    = r_dropped;
    assign io_bus.free_count = r_free_count;

endmodule

// File: tb/tb_rocket_pool.sv
// Directed bench for rocket_pool: default instance plus an AUTO_FIRE=1 instance.
module tb_rocket_pool;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #10 clk = ~clk;

    rocket_pool_if #(.N_SLOTS(15)) bus0 ();
    rocket_pool_if #(.N_SLOTS(15)) bus1 ();

    rocket_pool #(.N_SLOTS(15)) u_dut0 (
        .i_Clk(clk), .i_Reset_n(rst_n), .io_bus(bus0)
    );

    rocket_pool #(.N_SLOTS(15), .AUTO_FIRE(1), .COOLDOWN(8)) u_dut1 (
        .i_Clk(clk), .i_Reset_n(rst_n), .io_bus(bus1)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    // One frame_tick on both buses; outputs of that edge are visible on return.
    task automatic frame();
        bus0.frame_tick = 1'b1;
        bus1.frame_tick = 1'b1;
        @(negedge clk);
        bus0.frame_tick = 1'b0;
        bus1.frame_tick = 1'b0;
    endtask

    task automatic clear_inputs();
        bus0.frame_tick = 0; bus0.enable = 0; bus0.shoot = 0;
        bus0.ship_x = '0; bus0.ship_y = '0; bus0.hit = '0;
        bus1.frame_tick = 0; bus1.enable = 0; bus1.shoot = 0;
        bus1.ship_x = '0; bus1.ship_y = '0; bus1.hit = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        bus0.enable = 1'b1;
        bus1.enable = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        cyc(); cyc();
        checks++; if (bus0.active !== 15'h0) begin errors++; $display("FAIL reset_active: got %h exp 0000", bus0.active); end
        checks++; if (bus0.free_count !== 6'd15) begin errors++; $display("FAIL reset_free: got %0d exp 15", bus0.free_count); end
        checks++; if (bus0.fired !== 1'b0 || bus0.dropped !== 1'b0) begin errors++; $display("FAIL reset_pulses: got fired=%b dropped=%b exp 0 0", bus0.fired, bus0.dropped); end
        checks++; if (bus0.rock_y[0] !== 10'd0 || bus0.rock_x[14] !== 10'd0) begin errors++; $display("FAIL reset_pos: got y0=%0d x14=%0d exp 0 0", bus0.rock_y[0], bus0.rock_x[14]); end
        checks++; if (bus1.free_count !== 6'd15) begin errors++; $display("FAIL reset_free_auto: got %0d exp 15", bus1.free_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_fire_move();
        do_reset();
        bus0.ship_x = 10'd320; bus0.ship_y = 10'd440;
        bus0.shoot = 1'b1;
        frame();
        checks++; if (bus0.fired !== 1'b1) begin errors++; $display("FAIL fire_pulse: got %b exp 1", bus0.fired); end
        checks++; if (bus0.active !== 15'h0001) begin errors++; $display("FAIL fire_active: got %h exp 0001", bus0.active); end
        checks++; if (bus0.rock_x[0] !== 10'd320 || bus0.rock_y[0] !== 10'd432) begin errors++; $display("FAIL fire_pos: got (%0d,%0d) exp (320,432)", bus0.rock_x[0], bus0.rock_y[0]); end
        checks++; if (bus0.free_count !== 6'd14) begin errors++; $display("FAIL fire_free: got %0d exp 14", bus0.free_count); end
        cyc();
        checks++; if (bus0.fired !== 1'b0) begin errors++; $display("FAIL fire_one_cycle: got %b exp 0", bus0.fired); end
        // shoot still held: no new edge, rocket just moves
        frame();
        checks++; if (bus0.fired !== 1'b0 || bus0.rock_y[0] !== 10'd428 || bus0.active !== 15'h0001) begin errors++; $display("FAIL move1: got fired=%b y=%0d act=%h exp 0 428 0001", bus0.fired, bus0.rock_y[0], bus0.active); end
        bus0.shoot = 1'b0;
        frame();
        checks++; if (bus0.rock_y[0] !== 10'd424 || bus0.rock_x[0] !== 10'd320) begin errors++; $display("FAIL move2: got (%0d,%0d) exp (320,424)", bus0.rock_x[0], bus0.rock_y[0]); end
    endtask

    task automatic test_retire();
        do_reset();
        bus0.ship_x = 10'd50; bus0.ship_y = 10'd13;
        bus0.shoot = 1'b1; frame();
        checks++; if (bus0.rock_y[0] !== 10'd5 || bus0.active !== 15'h0001) begin errors++; $display("FAIL retire_spawn: got y=%0d act=%h exp 5 0001", bus0.rock_y[0], bus0.active); end
        bus0.shoot = 1'b0; frame();
        checks++; if (bus0.rock_y[0] !== 10'd1 || bus0.active !== 15'h0001) begin errors++; $display("FAIL retire_step: got y=%0d act=%h exp 1 0001", bus0.rock_y[0], bus0.active); end
        frame();
        checks++; if (bus0.active !== 15'h0000 || bus0.free_count !== 6'd15) begin errors++; $display("FAIL retire_done: got act=%h free=%0d exp 0000 15", bus0.active, bus0.free_count); end
        checks++; if (bus0.rock_y[0] === 10'd1021) begin errors++; $display("FAIL retire_wrap: got y=%0d exp not 1021", bus0.rock_y[0]); end
        // ship_y below the spawn offset clamps to the top row
        bus0.ship_y = 10'd3;
        bus0.shoot = 1'b1; frame();
        checks++; if (bus0.rock_y[0] !== 10'd0 || bus0.active !== 15'h0001) begin errors++; $display("FAIL spawn_clamp: got y=%0d act=%h exp 0 0001", bus0.rock_y[0], bus0.active); end
        bus0.shoot = 1'b0; frame();
        checks++; if (bus0.active !== 15'h0000) begin errors++; $display("FAIL clamp_retire: got act=%h exp 0000", bus0.active); end
    endtask

    task automatic test_full_and_hit();
        do_reset();
        bus0.ship_x = 10'd100; bus0.ship_y = 10'd440;
        for (int k = 0; k < 15; k++) begin
            bus0.shoot = 1'b1; frame();
            bus0.shoot = 1'b0; frame();
        end
        checks++; if (bus0.active !== 15'h7FFF || bus0.free_count !== 6'd0) begin errors++; $display("FAIL fill: got act=%h free=%0d exp 7fff 0", bus0.active, bus0.free_count); end
        bus0.shoot = 1'b1; frame();
        checks++; if (bus0.dropped !== 1'b1 || bus0.fired !== 1'b0) begin errors++; $display("FAIL drop_pulse: got dropped=%b fired=%b exp 1 0", bus0.dropped, bus0.fired); end
        checks++; if (bus0.active !== 15'h7FFF || bus0.free_count !== 6'd0) begin errors++; $display("FAIL drop_state: got act=%h free=%0d exp 7fff 0", bus0.active, bus0.free_count); end
        cyc();
        checks++; if (bus0.dropped !== 1'b0) begin errors++; $display("FAIL drop_one_cycle: got %b exp 0", bus0.dropped); end
        bus0.shoot = 1'b0; frame();
        bus0.hit = 15'h0008; cyc(); bus0.hit = '0;
        checks++; if (bus0.active !== 15'h7FF7 || bus0.free_count !== 6'd1) begin errors++; $display("FAIL hit3: got act=%h free=%0d exp 7ff7 1", bus0.active, bus0.free_count); end
        bus0.ship_x = 10'd200;
        bus0.shoot = 1'b1; frame();
        checks++; if (bus0.fired !== 1'b1 || bus0.active !== 15'h7FFF) begin errors++; $display("FAIL reuse3: got fired=%b act=%h exp 1 7fff", bus0.fired, bus0.active); end
        checks++; if (bus0.rock_x[3] !== 10'd200 || bus0.rock_y[3] !== 10'd432) begin errors++; $display("FAIL reuse3_pos: got (%0d,%0d) exp (200,432)", bus0.rock_x[3], bus0.rock_y[3]); end
        bus0.shoot = 1'b0; frame();
        // hit on slot 0 races a tick and a fire request while full
        bus0.hit = 15'h0001; bus0.shoot = 1'b1; frame(); bus0.hit = '0;
        checks++; if (bus0.active !== 15'h7FFE || bus0.free_count !== 6'd1) begin errors++; $display("FAIL race_state: got act=%h free=%0d exp 7ffe 1", bus0.active, bus0.free_count); end
        checks++; if (bus0.dropped !== 1'b1 || bus0.fired !== 1'b0) begin errors++; $display("FAIL race_drop: got dropped=%b fired=%b exp 1 0", bus0.dropped, bus0.fired); end
        bus0.shoot = 1'b0; frame();
        bus0.shoot = 1'b1; frame();
        checks++; if (bus0.fired !== 1'b1 || bus0.active !== 15'h7FFF || bus0.rock_y[0] !== 10'd432) begin errors++; $display("FAIL race_reuse: got fired=%b act=%h y0=%0d exp 1 7fff 432", bus0.fired, bus0.active, bus0.rock_y[0]); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus0.ship_x = 10'd320; bus0.ship_y = 10'd440;
        for (int k = 0; k < 6; k++) begin
            bus0.shoot = 1'b1; frame();
            bus0.shoot = 1'b0; frame();
        end
        checks++; if (bus0.active !== 15'h003F || bus0.free_count !== 6'd9) begin errors++; $display("FAIL six_live: got act=%h free=%0d exp 003f 9", bus0.active, bus0.free_count); end
        rst_n = 1'b0; bus0.shoot = 1'b1;
        frame();
        checks++; if (bus0.active !== 15'h0 || bus0.free_count !== 6'd15 || bus0.fired !== 1'b0 || bus0.dropped !== 1'b0) begin errors++; $display("FAIL midreset: got act=%h free=%0d fired=%b dropped=%b exp 0000 15 0 0", bus0.active, bus0.free_count, bus0.fired, bus0.dropped); end
        checks++; if (bus0.rock_x[0] !== 10'd0 || bus0.rock_y[5] !== 10'd0) begin errors++; $display("FAIL midreset_pos: got x0=%0d y5=%0d exp 0 0", bus0.rock_x[0], bus0.rock_y[5]); end
        rst_n = 1'b1;
    endtask

    task automatic test_enable();
        do_reset();
        bus0.enable = 1'b0;
        bus0.ship_x = 10'd320; bus0.ship_y = 10'd440;
        for (int k = 0; k < 3; k++) begin
            bus0.shoot = 1'b1; frame();
            checks++; if (bus0.fired !== 1'b0 || bus0.dropped !== 1'b0) begin errors++; $display("FAIL disabled_%0d: got fired=%b dropped=%b exp 0 0", k, bus0.fired, bus0.dropped); end
            bus0.shoot = 1'b0; frame();
        end
        checks++; if (bus0.active !== 15'h0) begin errors++; $display("FAIL disabled_active: got %h exp 0000", bus0.active); end
        // history still tracks shoot while disabled: enabling under a held key is not an edge
        bus0.shoot = 1'b1; frame();
        bus0.enable = 1'b1; frame();
        checks++; if (bus0.fired !== 1'b0) begin errors++; $display("FAIL enable_held: got %b exp 0", bus0.fired); end
        bus0.shoot = 1'b0; frame();
        bus0.shoot = 1'b1; frame();
        checks++; if (bus0.fired !== 1'b1 || bus0.active !== 15'h0001) begin errors++; $display("FAIL enable_fire: got fired=%b act=%h exp 1 0001", bus0.fired, bus0.active); end
    endtask

    task automatic test_auto_fire();
        logic exp_f;
        do_reset();
        bus1.ship_x = 10'd320; bus1.ship_y = 10'd440;
        bus1.shoot = 1'b1;
        for (int f = 0; f < 40; f++) begin
            frame();
            exp_f = ((f % 8) == 0);
            checks++; if (bus1.fired !== exp_f) begin errors++; $display("FAIL auto_frame%0d: got fired=%b exp %b", f, bus1.fired, exp_f); end
        end
        checks++; if (bus1.active !== 15'h001F || bus1.free_count !== 6'd10) begin errors++; $display("FAIL auto_slots: got act=%h free=%0d exp 001f 10", bus1.active, bus1.free_count); end
        checks++; if (bus1.rock_y[0] !== 10'd276 || bus1.rock_y[4] !== 10'd404) begin errors++; $display("FAIL auto_pos: got y0=%0d y4=%0d exp 276 404", bus1.rock_y[0], bus1.rock_y[4]); end
        bus1.shoot = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_fire_move();
        test_retire();
        test_full_and_hit();
        test_reset_midflight();
        test_enable();
        test_auto_fire();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rocket_pool.md
ROCKET_POOL -- requirements
Module: rocket_pool

Interface
REQ-001 Parameter N_SLOTS, default 15: number of concurrent rocket slots, range 1..32.
REQ-002 Parameter SPEED, default 4: pixels moved upward per frame, range 1..15.
REQ-003 Parameter COOLDOWN, default 8: frames between shots in auto-fire mode, range 1..255.
REQ-004 Parameter AUTO_FIRE, default 0: 0 fires on each press, 1 repeats while shoot is held.
REQ-005 Parameter SPAWN_OFS, default 8: spawn position in pixels above ship_y.
REQ-006 Clk  in  1  system clock (50 MHz); all logic on its rising edge.
REQ-007 Reset_n  in  1  synchronous, active-low reset.
REQ-008 frame_tick  in  1  single-cycle pulse, once per video frame.
REQ-009 enable  in  1  when 0, no new rockets are fired; existing rockets still move and retire.
REQ-010 shoot  in  1  level-sensitive fire request from keycode decode.
REQ-011 ship_x, ship_y  in  10 each  current ship position in pixels.
REQ-012 hit  in  N_SLOTS  per-slot collision pulse from collision detection.
REQ-013 active  out  N_SLOTS  slot i currently holds a live rocket.
REQ-014 rock_x, rock_y  out  N_SLOTS x 10 each  registered per-slot position.
REQ-015 fired  out  1  one-cycle pulse when a rocket is allocated.
REQ-016 dropped  out  1  one-cycle pulse when a fire is requested and no slot is free.
REQ-017 free_count  out  6  number of inactive slots, registered.

Function
REQ-018 The block updates on frame_tick only, except hit handling (REQ-022); outputs are registered, one-cycle latency.
REQ-019 On frame_tick, each active slot with rock_y >= SPEED SHALL set rock_y to rock_y - SPEED; rock_x is unchanged.
REQ-020 On frame_tick, an active slot with rock_y < SPEED SHALL retire (active=0); rock_y never wraps.
REQ-021 Fire request condition on frame_tick: AUTO_FIRE=0 -> shoot=1 and shoot sampled at the previous frame_tick was 0; AUTO_FIRE=1 -> shoot=1 and cooldown=0.
REQ-022 hit[i]=1 in any cycle SHALL clear active[i] on the next edge; hit overrides move, retire and spawn for that slot; hit on an inactive slot is ignored.
REQ-023 A valid fire request with enable=1 SHALL allocate the lowest-index slot that is inactive in the registered state; that slot gets rock_x=ship_x, rock_y=ship_y-SPAWN_OFS (0 if ship_y<SPAWN_OFS), active=1, and fired pulses.
REQ-024 A slot freed by hit or retire in the same cycle is not allocatable until the next frame_tick.
REQ-025 A newly spawned rocket does not move until the following frame_tick.
REQ-026 If no slot is free, dropped SHALL pulse, state is unchanged, and cooldown is not reloaded.
REQ-027 The 8-bit cooldown counter reloads to COOLDOWN on each fire and decrements, saturating at 0, on every other frame_tick.
REQ-028 free_count SHALL equal N_SLOTS minus popcount(active), updated on the same edge as active.
REQ-029 Requests with enable=0 produce neither fired nor dropped; the shoot history register still updates.

Reset
REQ-030 While Reset_n=0 at a Clk edge: active=0, rock_x=rock_y=0, fired=dropped=0, cooldown=0, shoot history=0, free_count=N_SLOTS.
REQ-031 Reset asserted mid-flight discards all rockets in that cycle; a frame_tick coincident with reset is ignored.

Structure
REQ-032 Shared package galaga_pkg holds coord_t (10-bit), SCREEN_W=640, SCREEN_H=480 and the slot record type (active, x, y).
REQ-033 One sub-module, lowest_free_enc, is a parametrised priority encoder producing the index and a found flag from ~active.

Verification
REQ-034 Reset, shoot rising edge with ship at (320,440), defaults -> slot 0 at (320,432), fired pulse, free_count=14; next tick y=428.
REQ-035 AUTO_FIRE=1, COOLDOWN=8, shoot held for 40 frames -> fires on frames 0,8,16,24,32 into slots 0..4.
REQ-036 Fill all 15 slots, press again -> dropped pulses, no state change; hit[3] -> next press allocates slot 3.
REQ-037 Rocket at y=5, SPEED=4 -> y=1 next tick, retired the tick after, never 1021.
REQ-038 hit[0] coincident with frame_tick and a fire request, slots 0..14 full -> slot 0 cleared, dropped pulses, slot 0 reused on the next request.
REQ-039 Reset_n low with 6 rockets active -> all outputs at reset values next edge; enable=0 with shoot edges -> no fired pulse.
